mem_port_arbiter: RTL and testbench

- Round-robin arbiter sharing one 32-bit memory/bus port among four requesters (e.g. IF fetch, MEM load/store, debug, DMA).
- Drives the 2-bit select of the 4:1 data/address mux that feeds the shared port, plus one-hot grants back to requesters.
- Holds a grant for the length of a transfer, with a hold-cycle timeout so a stuck requester cannot starve the others.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Round-robin arbiter that shares one 32-bit memory/bus port among four
// requesters (for example IF fetch, MEM load/store, debug and DMA).
//
// A grant is held for the length of one transfer. It is released when the
// transfer completes, when the owner drops its request, or when the hold
// limit is reached. On release the next owner is picked in the same cycle,
// so back-to-back transfers carry no idle bubble.
//
// Handshake: req[i] is level-held by requester i until its transfer is done.
// The grant gnt[i] appears on the edge after req[i] is first sampled and
// stays up until the release edge. A transfer completes on the cycle where
// xfer_done is high while gnt is non-zero. xfer_done is ignored while idle.
//
// Parameters
//   MAX_HOLD : maximum number of cycles a grant may be held (0 = no limit)
//   CNT_W    : hold counter width, 2**CNT_W must exceed MAX_HOLD
//
// Ports
//   clk       : system clock, all state updates on the rising edge
//   reset_n   : synchronous active-low reset
//   req       : request vector, bit i = requester i
//   xfer_done : shared port completes the current transfer this cycle
//   gnt       : registered one-hot grant, all-zero when idle
//   sel       : registered mux select (index of the granted requester);
//               keeps its last value while idle
//   busy      : high while a grant is active; this is the FSM state bit
//   timeout   : one-cycle pulse when the hold limit forces a release
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       xfer_done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    // FSM encoding. A single bit is enough, and busy exposes it directly.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam bit             HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    // Only used when HOLD_EN is set, so the wrap at MAX_HOLD=0 is harmless.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [0:0]       state;
    logic [1:0]       last_winner;
    logic [CNT_W-1:0] hold_cnt;

    // Combinational decision signals
    logic       owner_req;
    logic       rel_done;
    logic       rel_abandon;
    logic       rel_hold;
    logic       release_now;
    logic       timeout_now;
    logic [1:0] arb_ptr;
    logic [1:0] winner;
    logic       start_grant;

    // Round-robin pick: search upward starting at last+1 and wrap around.
    // The 2-bit index wraps naturally; at off=4 it returns to 'last', so the
    // previous winner is the lowest priority candidate.
    function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int off = 1; off <= 4; off++) begin
            idx = last + 2'(off);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        owner_req   = req[sel];
        rel_done    = 1'b0;
        rel_abandon = 1'b0;
        rel_hold    = 1'b0;
        release_now = 1'b0;
        timeout_now = 1'b0;

        if (state == ST_GRANT) begin
            rel_done    = xfer_done;
            rel_abandon = !owner_req;
            rel_hold    = HOLD_EN && (hold_cnt == HOLD_LAST);
            release_now = rel_done || rel_abandon || rel_hold;
            // Completion and abandon take precedence: the pulse only marks
            // a release that the hold limit alone caused.
            timeout_now = rel_hold && !rel_done && !rel_abandon;
        end

        // While granting, sel is the current owner k, so the search starts
        // at k+1. While idle, resume after the last winner.
        arb_ptr     = (state == ST_GRANT) ? sel : last_winner;
        winner      = rr_pick(req, arb_ptr);
        start_grant = (|req) && ((state == ST_IDLE) || release_now);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            gnt         <= 4'b0000;
            sel         <= 2'd0;
            timeout     <= 1'b0;
            hold_cnt    <= '0;
            last_winner <= 2'd3;
        end else begin
            timeout <= timeout_now;
            if (start_grant) begin
                state       <= ST_GRANT;
                gnt         <= 4'b0001 << winner;
                sel         <= winner;
                last_winner <= winner;
                hold_cnt    <= '0;
            end else if (release_now) begin
                // Released with nobody waiting: sel keeps the old owner.
                state    <= ST_IDLE;
                gnt      <= 4'b0000;
                hold_cnt <= '0;
            end else if ((state == ST_GRANT) && (hold_cnt != CNT_MAX)) begin
                // Saturating count of cycles held without release.
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end

    assign busy = (state == ST_GRANT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. A behavioural model (owner index, last
// winner, cycles held) predicts gnt/sel/busy/timeout for every clock, and
// directed scenarios add explicit checks on grant order, hold length and
// reset behaviour. A random phase closes with a fairness check.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int MAX_HOLD = 16;
    localparam int CNT_W    = 5;
    localparam int HOLD_CAP = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic       xfer_done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mem_port_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .xfer_done (xfer_done),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .timeout   (timeout)
    );

    // ---------------- counters ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // owner = -1 means idle; last = previous winner index.
    int         m_owner;
    int         m_last;
    int         m_hold;
    logic [1:0] m_sel;
    logic       m_tmo;
    logic [3:0] exp_q[$];

    function automatic int m_pick(input logic [3:0] r, input int after);
        for (int j = 1; j <= 4; j++)
            if (r[(after + j) % 4]) return (after + j) % 4;
        return -1;
    endfunction

    // Apply one rising edge with the currently driven inputs.
    task automatic model_update();
        int  w;
        bit  done_c, aband_c, hold_c;
        if (!reset_n) begin
            m_owner = -1; m_last = 3; m_hold = 0; m_sel = 2'd0; m_tmo = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                w = m_pick(req, m_last);
                if (w >= 0) begin
                    m_owner = w; m_last = w; m_sel = 2'(w); m_hold = 0;
                end
            end else begin
                done_c  = (xfer_done == 1'b1);
                aband_c = (req[m_owner] == 1'b0);
                hold_c  = (MAX_HOLD != 0) && (m_hold == MAX_HOLD - 1);
                if (done_c || aband_c || hold_c) begin
                    m_tmo = hold_c && !done_c && !aband_c;
                    w = m_pick(req, m_owner);
                    if (w >= 0) begin
                        m_owner = w; m_last = w; m_sel = 2'(w); m_hold = 0;
                    end else begin
                        m_owner = -1; m_hold = 0;
                    end
                end else if (m_hold < HOLD_CAP) begin
                    m_hold++;
                end
            end
        end
        exp_q.push_back((m_owner < 0) ? 4'b0000 : 4'(1 << m_owner));
    endtask

    // ---------------- scoreboard ----------------
    bit         track_fair = 0;
    logic [3:0] prev_gnt   = 4'b0000;
    int         waits[4];
    int         max_wait   = 0;

    task automatic check_outputs();
        logic [3:0] exp_g;
        exp_g = exp_q.pop_front();
        chk("gnt", 32'(gnt), 32'(exp_g));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("busy", 32'(busy), 32'(exp_g != 4'b0000));
        chk("timeout", 32'(timeout), 32'(m_tmo));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (busy) chk("sel_matches_gnt", 32'(gnt[sel]), 32'd1);
        if (track_fair) begin
            if (gnt != 4'b0000 && gnt != prev_gnt)
                for (int i = 0; i < 4; i++)
                    if (req[i] && !gnt[i]) waits[i]++;
            for (int i = 0; i < 4; i++) begin
                if (!req[i] || gnt[i]) waits[i] = 0;
                if (waits[i] > max_wait) max_wait = waits[i];
            end
        end
        prev_gnt = gnt;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = 4'b0000;
        xfer_done = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    // Safety net in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int         order[$];
        int         held;
        int         tmo_cnt;
        logic [3:0] pg;

        reset_n = 1'b0; req = 4'b0000; xfer_done = 1'b0;
        m_owner = -1; m_last = 3; m_hold = 0; m_sel = 2'd0; m_tmo = 1'b0;
        for (int i = 0; i < 4; i++) waits[i] = 0;

        // Reset state
        do_reset();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);

        // All four requesting, xfer_done every second cycle: order 0,1,2,3,0
        req = 4'b1111;
        pg  = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            xfer_done = (i % 2 == 1);
            step();
            if (gnt != 4'b0000 && gnt != pg) order.push_back(int'(sel));
            pg = gnt;
        end
        chk("rr_order_len_ge5", 32'(order.size() >= 5), 32'd1);
        if (order.size() >= 5) begin
            chk("rr_order0", 32'(order[0]), 32'd0);
            chk("rr_order1", 32'(order[1]), 32'd1);
            chk("rr_order2", 32'(order[2]), 32'd2);
            chk("rr_order3", 32'(order[3]), 32'd3);
            chk("rr_order4", 32'(order[4]), 32'd0);
        end

        // Single requester 2, done after 3 cycles, sel sticks at 2 when idle
        do_reset();
        req = 4'b0100; xfer_done = 1'b0;
        step();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_sel", 32'(sel), 32'd2);
        step();
        step();
        req = 4'b0000; xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        step();
        step();
        chk("idle_gnt", 32'(gnt), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_sel_kept", 32'(sel), 32'd2);

        // Hold limit: requester 0 stuck, requester 1 waiting
        do_reset();
        req = 4'b0001; xfer_done = 1'b0;
        held = 0; tmo_cnt = 0;
        step();
        if (gnt === 4'b0001) held++;
        req = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            step();
            if (gnt === 4'b0001) held++;
            if (timeout === 1'b1) begin
                tmo_cnt++;
                chk("tmo_next_gnt", 32'(gnt), 32'h2);
                chk("tmo_next_sel", 32'(sel), 32'd1);
            end
        end
        chk("hold_cycles", 32'(held), 32'(MAX_HOLD));
        chk("tmo_pulses", 32'(tmo_cnt), 32'd1);

        // Completion at the last hold cycle wins over the timeout
        do_reset();
        req = 4'b0010;
        step();
        req = 4'b1010;
        for (int i = 0; i < 15; i++) step();
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        chk("done_at_limit_tmo", 32'(timeout), 32'd0);
        chk("done_at_limit_gnt", 32'(gnt), 32'h8);

        // Abandon mid-transfer releases without a timeout
        do_reset();
        req = 4'b0010;
        step();
        step();
        step();
        req = 4'b0000;
        step();
        chk("abandon_gnt", 32'(gnt), 32'd0);
        chk("abandon_tmo", 32'(timeout), 32'd0);

        // Reset while owner 2 holds the port, then pointer restarts at 0
        do_reset();
        req = 4'b0100;
        step();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midreset_gnt", 32'(gnt), 32'd0);
        chk("midreset_sel", 32'(sel), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_tmo", 32'(timeout), 32'd0);
        req = 4'b1010;
        step();
        chk("after_reset_winner", 32'(gnt), 32'h2);

        // Random traffic: requests change slowly so transfers span cycles
        do_reset();
        track_fair = 1;
        req = 4'(1 + $urandom_range(0, 14));
        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            xfer_done = ($urandom_range(0, 3) == 0);
            step();
        end
        track_fair = 0;
        chk("max_wait_le3", 32'(max_wait <= 3), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
